rsa_modexp: RTL and testbench

Modular exponentiation engine that computes result = base^exponent mod modulus on W-bit unsigned operands. It sits directly downstream of the RSA operand register file and takes its three operands in parallel once all bytes are loaded. It uses right-to-left square-and-multiply built on a bit-serial interleaved modular multiplier, at one multiplier bit per clock. The result feeds the read-back path for byte-wise output.

---
 rtl/rsa_modexp_if.sv | 31 +++
 rtl/rsa_modexp.sv | 233 +++++++++++++++++++++++
 tb/tb_rsa_modexp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_if.sv
// rsa_modexp_if: operand/result bundle between the RSA operand register file
// and the modular exponentiation engine.
//   start    - request an operation (only honoured while the engine is idle)
//   base     - base operand, any value
//   exponent - exponent operand
//   modulus  - modulus operand
//   result   - base^exponent mod modulus, held until the next accepted start
//   done     - one-cycle pulse when result becomes valid
//   busy     - high while a computation is in flight
// The master modport is the requester; the slave modport is the engine.
interface rsa_modexp_if #(
  parameter int W = 256
);
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic [W-1:0] result;
  logic         done;
  logic         busy;

  modport master (
    output start, base, exponent, modulus,
    input  result, done, busy
  );

  modport slave (
    input  start, base, exponent, modulus,
    output result, done, busy
  );
endinterface

// File: rtl/rsa_modexp.sv
// rsa_modexp: computes result = base^exponent mod modulus on W-bit operands
// using right-to-left square-and-multiply. Every modular product is formed by
// a bit-serial interleaved multiplier that consumes one multiplier bit per
// clock, so each multiplication takes exactly W cycles and multiplications run
// back to back.
// Ports:
//   clk   - clock, all state changes on its rising edge
//   reset - asynchronous active-high reset; returns to IDLE, clears outputs
//   bus   - rsa_modexp_if slave modport (start/operands in, result/done/busy out)
module rsa_modexp #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         reset,
  rsa_modexp_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL,
    SQR,
    DONE
  } state_t;

  state_t state_reg, state_next;

  // Captured operands. e_sh_reg is the exponent shifted right once per
  // squaring, so bit 0 is always the exponent bit currently being processed.
  logic [W-1:0] base_reg;
  logic [W-1:0] mod_reg;
  logic [W-1:0] e_sh_reg;
  logic [W-1:0] s_reg;      // running square: base^(2^j) mod n
  logic [W-1:0] r_reg;      // running product
  logic [W-1:0] result_reg;

  // Multiplier accumulator is two bits wider than the operands: doubling a
  // value just below n and then adding x can reach almost 3n.
  logic [W+1:0] p_reg;
  logic [CW-1:0] cnt_reg;   // multiplier bit index, counts W-1 down to 0

  // Control strobes from the FSM
  logic         capture;
  logic         load_s;
  logic         load_r;
  logic         shift_e;
  logic         load_result;
  logic [W-1:0] result_value;

  logic         mul_last;
  logic         e_upper;
  logic         in_mul;

  // Multiplier datapath
  logic [W-1:0] x_op;
  logic [W-1:0] y_op;
  logic         y_bit;
  logic [W+1:0] n_ext;
  logic [W+1:0] dbl;
  logic [W+1:0] dbl_red;
  logic [W+1:0] sum;
  logic [W+1:0] p_step;

  assign mul_last = (cnt_reg == '0);
  assign e_upper  = |e_sh_reg[W-1:1];
  assign in_mul   = (state_reg == REDUCE) || (state_reg == MUL) || (state_reg == SQR);

  // Operand selection: REDUCE multiplies 1 by base to fold base into [0, n).
  always_comb begin
    x_op = '0;
    y_op = '0;
    case (state_reg)
      REDUCE: begin
        x_op = W'(1);
        y_op = base_reg;
      end
      MUL: begin
        x_op = r_reg;
        y_op = s_reg;
      end
      SQR: begin
        x_op = s_reg;
        y_op = s_reg;
      end
      default: begin
        x_op = '0;
        y_op = '0;
      end
    endcase
  end

  assign y_bit   = y_op[cnt_reg];
  assign n_ext   = {2'b00, mod_reg};
  // p_reg is always below n (< 2^W), so the shift never drops a set bit.
  assign dbl     = p_reg << 1;
  assign dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
  assign sum     = dbl_red + (y_bit ? {2'b00, x_op} : {(W+2){1'b0}});
  assign p_step  = (sum >= n_ext) ? (sum - n_ext) : sum;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next   = state_reg;
    capture      = 1'b0;
    load_s       = 1'b0;
    load_r       = 1'b0;
    shift_e      = 1'b0;
    load_result  = 1'b0;
    result_value = r_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          // Modulus 0 or 1: nothing to compute, answer is 0.
          if (bus.modulus[W-1:1] == '0) begin
            state_next   = DONE;
            load_result  = 1'b1;
            result_value = '0;
          end else begin
            state_next = REDUCE;
          end
        end
      end
      REDUCE: begin
        if (mul_last) begin
          load_s = 1'b1;
          if (e_sh_reg[0]) begin
            state_next = MUL;
          end else if (e_upper) begin
            state_next = SQR;
          end else begin
            // Exponent zero: R is still 1.
            state_next   = DONE;
            load_result  = 1'b1;
            result_value = r_reg;
          end
        end
      end
      MUL: begin
        if (mul_last) begin
          load_r = 1'b1;
          if (e_upper) begin
            state_next = SQR;
          end else begin
            state_next   = DONE;
            load_result  = 1'b1;
            result_value = p_step[W-1:0];
          end
        end
      end
      SQR: begin
        if (mul_last) begin
          load_s  = 1'b1;
          shift_e = 1'b1;
          // A squaring only happens when some higher bit is set, so if the
          // next bit is clear another squaring must follow.
          if (e_sh_reg[1]) begin
            state_next = MUL;
          end else begin
            state_next = SQR;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_reg   <= '0;
      mod_reg    <= '0;
      e_sh_reg   <= '0;
      s_reg      <= '0;
      r_reg      <= '0;
      result_reg <= '0;
      p_reg      <= '0;
      cnt_reg    <= CNT_LAST;
    end else begin
      if (capture) begin
        base_reg <= bus.base;
        mod_reg  <= bus.modulus;
        e_sh_reg <= bus.exponent;
        r_reg    <= W'(1);
        p_reg    <= '0;
        cnt_reg  <= CNT_LAST;
      end else if (in_mul) begin
        // Re-arm immediately so the next multiplication starts the following
        // cycle with a cleared accumulator.
        if (mul_last) begin
          p_reg   <= '0;
          cnt_reg <= CNT_LAST;
        end else begin
          p_reg   <= p_step;
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
      if (load_s) begin
        s_reg <= p_step[W-1:0];
      end
      if (load_r) begin
        r_reg <= p_step[W-1:0];
      end
      if (shift_e) begin
        e_sh_reg <= e_sh_reg >> 1;
      end
      if (load_result) begin
        result_reg <= result_value;
      end
    end
  end

  assign bus.result = result_reg;
  assign bus.done   = (state_reg == DONE);
  assign bus.busy   = in_mul;

endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: self-checking bench for rsa_modexp at W=16. Hand-computed
// vectors from a table, hand-written start-while-busy and reset-abort
// sequences, then random operands checked against a plain-arithmetic model
// (repeated multiplication mod n, cycle count from popcount/msb).
module tb_rsa_modexp;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_modexp_if #(.W(W)) bus ();

  rsa_modexp #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] held_result = '0;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] r;
    int           cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint ref_modexp(input longint b, input longint e, input longint m);
    longint r;
    if (m < 2) return 0;
    r = 1;
    for (longint k = 0; k < e; k++) r = (r * (b % m)) % m;
    return r;
  endfunction

  function automatic int ref_cycles(input longint m, input longint e);
    int pc;
    int hi;
    pc = 0;
    hi = 0;
    if (m < 2) return 1;
    for (int k = 0; k < W; k++) begin
      if (((e >> k) & 1) == 1) begin
        pc++;
        hi = k;
      end
    end
    return (1 + pc + hi) * W + 1;
  endfunction

  // Issue one operation. poke_cycle: cycle at which a second start (with
  // other operands) is raised for one cycle. abort_cycle: cycle at which
  // reset is asserted. Negative values disable either.
  task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] exp_r, input int exp_done,
                        input int poke_cycle, input int abort_cycle);
    int c;
    int busy_cnt;
    int done_cycle;
    bit seen_done;
    bit result_moved;
    bit stray;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = m;
    @(posedge clk);           // cycle 0: start sampled
    #1;
    bus.start    = 1'b0;
    bus.base     = W'($urandom);
    bus.exponent = W'($urandom);
    bus.modulus  = W'($urandom);
    c = 1;
    busy_cnt = 0;
    done_cycle = -1;
    seen_done = 0;
    result_moved = 0;
    while (!seen_done && c <= exp_done + 5) begin
      if (c == abort_cycle) begin
        reset = 1'b1;
        #1;
        check({tag, " abort busy"}, bus.busy, 0);
        check({tag, " abort done"}, bus.done, 0);
        check({tag, " abort result"}, bus.result, 0);
        held_result = '0;
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < exp_done + 20; k++) begin
          @(posedge clk);
          #1;
          if (bus.done || bus.busy) stray = 1;
        end
        check({tag, " no done after abort"}, stray, 0);
        $display("[TB] %s aborted at cycle %0d", tag, c);
        return;
      end
      if (bus.done) begin
        seen_done = 1;
        done_cycle = c;
        check({tag, " busy in done cycle"}, bus.busy, 0);
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.result !== held_result) result_moved = 1;
        if (c == poke_cycle) begin
          bus.start    = 1'b1;
          bus.base     = 3;
          bus.exponent = 5;
          bus.modulus  = 11;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        c++;
      end
    end
    bus.start = 1'b0;
    check({tag, " done seen"}, seen_done, 1);
    check({tag, " done cycle"}, done_cycle, exp_done);
    check({tag, " result"}, bus.result, exp_r);
    check({tag, " busy cycles"}, busy_cnt, exp_done - 1);
    check({tag, " result stable before done"}, result_moved, 0);
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, bus.done, 0);
    check({tag, " result held"}, bus.result, exp_r);
    held_result = exp_r;
    $display("[TB] %s b=%0d e=%0d m=%0d -> result=%0d done@%0d (expect %0d @%0d)",
             tag, b, e, m, bus.result, done_cycle, exp_r, exp_done);
  endtask

  initial begin
    logic [W-1:0] rb, re, rm;
    vecs[0] = '{b: 4,     e: 13, m: 497,   r: 445, cyc: 113};
    vecs[1] = '{b: 2,     e: 0,  m: 7,     r: 1,   cyc: 17};
    vecs[2] = '{b: 10,    e: 3,  m: 7,     r: 6,   cyc: 65};
    vecs[3] = '{b: 5,     e: 9,  m: 1,     r: 0,   cyc: 1};
    vecs[4] = '{b: 5,     e: 9,  m: 0,     r: 0,   cyc: 1};
    vecs[5] = '{b: 0,     e: 5,  m: 13,    r: 0,   cyc: 81};
    vecs[6] = '{b: 0,     e: 0,  m: 13,    r: 1,   cyc: 17};
    vecs[7] = '{b: 7,     e: 1,  m: 2,     r: 1,   cyc: 33};
    vecs[8] = '{b: 3,     e: 4,  m: 5,     r: 1,   cyc: 65};
    vecs[9] = '{b: 65535, e: 2,  m: 65521, r: 196, cyc: 49};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", bus.result, 0);
    check("reset done", bus.done, 0);
    check("reset busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].r, vecs[i].cyc, -1, -1);
    end

    // start while busy must be ignored
    run_op("poke40", 4, 13, 497, 445, 113, 40, -1);
    // reset mid-operation, then a clean rerun
    run_op("abort50", 4, 13, 497, 445, 113, -1, 50);
    run_op("rerun", 4, 13, 497, 445, 113, -1, -1);

    for (int i = 0; i < 25; i++) begin
      rb = W'($urandom);
      re = W'($urandom);
      rm = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      run_op($sformatf("rnd%0d", i), rb, re, rm, W'(ref_modexp(rb, re, rm)),
             ref_cycles(rm, re), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
